// File: rtl/alu_mul_seq_if.sv
// Bus bundle between the shift-add multiplier, its launching control unit and the shared ALU.
// slave = the multiplier; master = everything driving it (control unit + ALU).
interface alu_mul_seq_if #(
  parameter int N = 32
);
  logic         start_i;
  logic         signed_i;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  logic         busy_o;
  logic         done_o;
  logic [N-1:0] hi_o;
  logic [N-1:0] lo_o;
  logic [N-1:0] alu_a_o;
  logic [N-1:0] alu_b_o;
  logic         alu_c_o;
  logic         alu_invert_o;
  logic [3:0]   alu_op_o;
  logic [N-1:0] alu_res_i;
  logic         alu_c_i;

  modport slave (
    input  start_i, signed_i, a_i, b_i, alu_res_i, alu_c_i,
    output busy_o, done_o, hi_o, lo_o,
           alu_a_o, alu_b_o, alu_c_o, alu_invert_o, alu_op_o
  );

  modport master (
    output start_i, signed_i, a_i, b_i, alu_res_i, alu_c_i,
    input  busy_o, done_o, hi_o, lo_o,
           alu_a_o, alu_b_o, alu_c_o, alu_invert_o, alu_op_o
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier that borrows the execute-stage ALU adder for N iterations
// and returns the 2N-bit product as HI/LO words. Signed operands are handled as sign-magnitude.
module alu_mul_seq #(
  parameter int          N      = 32,
  parameter logic [3:0]  OP_ADD = 4'b0010
) (
  input logic          clk_i,
  input logic          rst_i,
  alu_mul_seq_if.slave bus
);

  localparam int CNT_W = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]     state;
  logic [N-1:0]   mcand;
  logic [N-1:0]   acc_hi;
  logic [N-1:0]   acc_lo;
  logic [CNT_W-1:0] cnt;
  logic           neg;
  logic           done;
  logic [N-1:0]   hi;
  logic [N-1:0]   lo;

  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic [N-1:0]   alu_a;
  logic [N-1:0]   alu_b;
  logic [2*N-1:0] prod;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    a_mag = bus.a_i;
    b_mag = bus.b_i;
    if (bus.signed_i && bus.a_i[N-1]) a_mag = -bus.a_i;
    if (bus.signed_i && bus.b_i[N-1]) b_mag = -bus.b_i;

    alu_a = '0;
    alu_b = '0;
    if (state == S_ITER) begin
      alu_a = acc_hi;
      alu_b = acc_lo[0] ? mcand : '0;
    end

    // The magnitude of -2^(N-1) fits in N unsigned bits, so restoring the sign is always exact.
    prod = neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples the
  // values from before the edge regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            mcand  <= a_mag;
            acc_lo <= b_mag;
            acc_hi <= '0;
            cnt    <= '0;
            neg    <= bus.signed_i & (bus.a_i[N-1] ^ bus.b_i[N-1]);
            state  <= S_ITER;
          end
        end
        S_ITER: begin
          // Adder carry becomes the new top bit as the partial product shifts right.
          {acc_hi, acc_lo} <= {bus.alu_c_i, bus.alu_res_i, acc_lo[N-1:1]};
          cnt              <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(N - 1)) state <= S_FIN;
        end
        S_FIN: begin
          {hi, lo} <= prod;
          done     <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy_o       = (state != S_IDLE);
  assign bus.done_o       = done;
  assign bus.hi_o         = hi;
  assign bus.lo_o         = lo;
  assign bus.alu_a_o      = alu_a;
  assign bus.alu_b_o      = alu_b;
  assign bus.alu_c_o      = 1'b0;
  assign bus.alu_invert_o = 1'b0;
  assign bus.alu_op_o     = OP_ADD;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: behavioural ALU adder, a product scoreboard popped on done_o, and
// cycle-accurate checks of latency and ALU drive for every multiply.
module tb_alu_mul_seq;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_mul_seq_if #(.N(N)) bus ();

  alu_mul_seq #(.N(N), .OP_ADD(4'b0010)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Behavioural stand-in for the ALU: add with optional invert of b and carry-in.
  logic [N-1:0] alu_b_eff;
  assign alu_b_eff = bus.alu_invert_o ? ~bus.alu_b_o : bus.alu_b_o;
  assign {bus.alu_c_i, bus.alu_res_i} = (bus.alu_op_o == 4'b0010)
      ? ({1'b0, bus.alu_a_o} + {1'b0, alu_b_eff} + {{N{1'b0}}, bus.alu_c_o})
      : '0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sgn;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
  } vec_t;

  vec_t           vecs[9];
  logic [2*N-1:0] sb_q[$];
  int             checks   = 0;
  int             failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                        input logic sgn);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (sgn) begin
      sa = {{32{a[N-1]}}, a};
      sb = {{32{b[N-1]}}, b};
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Scoreboard consumer: every done_o pulse must match the oldest outstanding product.
  always @(negedge clk) begin
    if (!rst && bus.done_o === 1'b1) begin
      if (sb_q.size() == 0) check("spurious_done", bus.done_o, 1'b0);
      else check("product", {bus.hi_o, bus.lo_o}, sb_q.pop_front());
    end
  end

  // Launch one multiply and follow it cycle by cycle; returns in the done_o cycle.
  task automatic run_mul(input logic [N-1:0] a, input logic [N-1:0] b, input logic sgn,
                         input logic [63:0] exp, input bit inject);
    logic [N-1:0] am;
    logic [N-1:0] bm;
    am = (sgn && a[N-1]) ? -a : a;
    bm = (sgn && b[N-1]) ? -b : b;
    bus.start_i  = 1'b1;
    bus.signed_i = sgn;
    bus.a_i      = a;
    bus.b_i      = b;
    sb_q.push_back(exp);
    tick();
    bus.start_i = 1'b0;
    for (int j = 0; j <= N; j++) begin
      check("busy_running", bus.busy_o, 1'b1);
      check("done_early", bus.done_o, 1'b0);
      check("alu_b", bus.alu_b_o, (j < N) ? (bm[j] ? am : '0) : '0);
      check("alu_op", bus.alu_op_o, 4'b0010);
      check("alu_c", bus.alu_c_o, 1'b0);
      check("alu_invert", bus.alu_invert_o, 1'b0);
      if (j == N) check("alu_a_fin", bus.alu_a_o, '0);
      bus.a_i      = $urandom;
      bus.b_i      = $urandom;
      bus.signed_i = 1'($urandom_range(0, 1));
      bus.start_i  = (inject && j == 10);
      tick();
    end
    bus.start_i = 1'b0;
    check("done_latency", bus.done_o, 1'b1);
    check("busy_fall", bus.busy_o, 1'b0);
  endtask

  initial begin
    vecs[0] = '{32'd7,        32'd6,        1'b0, 32'h0000_0000, 32'h0000_002A};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{32'hFFFF_FFFD, 32'd5,        1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000};
    vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000};
    vecs[7] = '{32'd5,        32'h0000_0002, 1'b0, 32'h0000_0000, 32'h0000_000A};
    vecs[8] = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE};

    bus.start_i  = 1'b0;
    bus.signed_i = 1'b0;
    bus.a_i      = '0;
    bus.b_i      = '0;
    rst          = 1'b1;
    repeat (3) tick();
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_done", bus.done_o, 1'b0);
    check("rst_hi", bus.hi_o, '0);
    check("rst_lo", bus.lo_o, '0);
    check("rst_alu_a", bus.alu_a_o, '0);
    check("rst_alu_b", bus.alu_b_o, '0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_mul(vecs[i].a, vecs[i].b, vecs[i].sgn, {vecs[i].hi, vecs[i].lo}, 1'b0);
      tick();
      tick();
    end

    // Back-to-back random multiplies: each new start is driven in the previous done_o cycle.
    for (int i = 0; i < 6; i++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      ra = $urandom;
      rb = $urandom;
      run_mul(ra, rb, 1'(i % 2), model(ra, rb, 1'(i % 2)), 1'b0);
    end
    tick();

    // Start pulsed mid-operation is ignored; then a back-to-back start in the done_o cycle.
    run_mul(32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A, 1'b1);
    run_mul(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    tick();

    // Abort at iteration 15: outputs clear and the abandoned product never completes.
    bus.start_i  = 1'b1;
    bus.signed_i = 1'b0;
    bus.a_i      = 32'h1234_5678;
    bus.b_i      = 32'h0000_0777;
    sb_q.push_back(model(32'h1234_5678, 32'h0000_0777, 1'b0));
    tick();
    bus.start_i = 1'b0;
    repeat (15) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    check("abort_busy", bus.busy_o, 1'b0);
    check("abort_done", bus.done_o, 1'b0);
    check("abort_hi", bus.hi_o, '0);
    check("abort_lo", bus.lo_o, '0);
    check("abort_alu_a", bus.alu_a_o, '0);
    for (int i = 0; i < 40; i++) begin
      tick();
      check("abort_no_done", bus.done_o, 1'b0);
    end

    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);
    repeat (3) tick();
    check("hold_hi", bus.hi_o, 32'hFFFF_FFFE);
    check("hold_lo", bus.lo_o, 32'h0000_0001);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Sequential shift-add multiplier controller that wraps the N-bit ALU.
- It drives the ALU operand and control inputs each cycle (upstream role) and registers the ALU sum and carry-out (downstream role).
- The ALU's ripple adder is reused to form a 2N-bit product over N iterations, and the result is delivered to the datapath as HI/LO words.
- It sits beside the ALU in the execute path and is launched by the control unit for multiply instructions.

Parameters:
- N, 32, operand width; must match the ALU width.
- OP_ADD, 4'b0010, ALU operation code that selects addition.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  request to begin a multiply; sampled only in IDLE
- signed_i  in  1  1 = two's-complement operands, 0 = unsigned; captured with start_i
- a_i  in  N  multiplicand
- b_i  in  N  multiplier
- busy_o  out  1  high while a multiply is in progress
- done_o  out  1  one-cycle pulse when hi_o/lo_o are updated
- hi_o  out  N  upper half of the product (registered, held until the next done_o)
- lo_o  out  N  lower half of the product (registered, held until the next done_o)
- alu_a_o  out  N  to ALU a_i
- alu_b_o  out  N  to ALU b_i
- alu_c_o  out  1  to ALU c_i; constant 0
- alu_invert_o  out  1  to ALU invert_i; constant 0
- alu_op_o  out  4  to ALU operacion_i; constant OP_ADD
- alu_res_i  in  N  from ALU resultado_o; combinational, same cycle
- alu_c_i  in  1  from ALU c_o; combinational, same cycle

Behaviour:
- Reset (rst_i high at an edge, in any state, including mid-operation):
  - state to IDLE.
  - busy_o=0, done_o=0, hi_o=0, lo_o=0.
  - iteration counter, accumulator and sign flag cleared.
  - Any in-flight multiply is abandoned with no done_o.
- Internal registers:
  - mcand (N bits).
  - acc_hi (N bits).
  - acc_lo (N bits; initially holds the multiplier).
  - cnt (ceil(log2(N+1)) bits).
  - neg (1 bit).
- States and transitions:
  - IDLE: busy_o=0.
    - If start_i=1: capture operands.
      - signed_i=1: capture |a_i| and |b_i| (local two's-complement negation when the MSB is 1), and set neg = a_i[N-1] XOR b_i[N-1].
      - signed_i=0: capture raw operands, neg=0.
    - Load: mcand=|a|, acc_lo=|b|, acc_hi=0, cnt=0. Go to ITER.
    - start_i=0: stay in IDLE.
  - ITER: busy_o=1.
    - ALU drive: alu_a_o=acc_hi; alu_b_o = acc_lo[0] ? mcand : 0.
    - Each edge: {acc_hi, acc_lo} <= {alu_c_i, alu_res_i, acc_lo[N-1:1]}, and cnt increments.
    - After the edge where cnt reaches N-1 (N iterations total), go to FIN.
  - FIN: busy_o=1.
    - Compute P = neg ? (two's complement of {acc_hi, acc_lo} over 2N bits) : {acc_hi, acc_lo}.
    - At the edge: {hi_o, lo_o} <= P, done_o <= 1, state <= IDLE.
- Outside ITER: alu_a_o=0 and alu_b_o=0.
- Latency: start accepted at edge k → busy_o=1 from edge k+1 → done_o=1 for exactly the cycle after edge k+N+1. busy_o falls at the same edge that raises done_o.
- start_i while busy_o=1 is ignored; it is not queued.
- start_i=1 in the cycle done_o=1 (state is IDLE) is accepted: back-to-back operation is legal.
- a_i, b_i and signed_i are don't-care after the capture edge.
- Arithmetic:
  - The unsigned product is exact in 2N bits, with no overflow flag.
  - Signed: |−2^(N−1)| = 2^(N−1), which is representable as an unsigned N-bit value, so every signed product is exact.
  - A zero product with neg=1 stays 0, since the two's complement of 0 is 0.

Test Plan:
- N=32, unsigned, a=7, b=6 → done_o exactly 33 cycles after the start edge; hi=0x00000000, lo=0x0000002A; busy_o high for 33 cycles.
- Unsigned, a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Signed, a=−3 (0xFFFFFFFD), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Signed, a=0x80000000, b=0xFFFFFFFF → hi=0, lo=0x80000000.
- start_i pulsed again at cycle 10 of a running multiply with different operands → ignored; the original result appears with unchanged timing. A new start in the done_o cycle → second result exactly 33 cycles later.
- rst_i asserted at iteration 15 → next cycle busy_o=0, hi/lo=0, and no done_o ever. A subsequent start produces a correct result.
- Every ITER cycle: alu_op_o=0010, alu_c_o=0, alu_invert_o=0; alu_b_o=0 whenever the current multiplier LSB is 0 (check with b=0x00000002).
